// File: rtl/branch_hazard_unit_pkg.sv
// Shared MIPS definitions: branch opcodes, operand-forwarding selects and
// branch-hazard FSM state encodings.
package branch_hazard_unit_pkg;

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  function automatic logic [1:0] max2(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/branch_hazard_unit_src_check.sv
// Per-source hazard check for an ID-stage branch operand: forwarding select
// and the number of stall cycles this operand needs before it can be compared.
module src_hazard_check
  import branch_hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int FWD_EN     = 1
) (
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  ex_regwrite,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  mem_regwrite,
  input  logic                  mem_memread,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  wb_regwrite,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  output logic [1:0]            fwd_sel,
  output logic [1:0]            need
);

  logic live;
  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  // $0 is hard-wired, so it never depends on an in-flight producer.
  assign live    = (src != '0);
  assign ex_hit  = live && ex_regwrite  && (ex_rd  == src);
  assign mem_hit = live && mem_regwrite && (mem_rd == src);
  assign wb_hit  = live && wb_regwrite  && (wb_rd  == src);

  always_comb begin
    fwd_sel = FWD_RF;
    need    = 2'd0;
    if (FWD_EN != 0) begin
      if (mem_hit && !mem_memread) fwd_sel = FWD_EXMEM;
      else if (wb_hit)             fwd_sel = FWD_MEMWB;

      if (ex_hit && ex_memread)        need = 2'd2;
      else if (ex_hit)                 need = 2'd1;
      else if (mem_hit && mem_memread) need = 2'd1;
    end else begin
      // Without forwarding the branch waits until the producer has written back.
      if (ex_hit)       need = 2'd3;
      else if (mem_hit) need = 2'd2;
      else if (wb_hit)  need = 2'd1;
    end
  end

endmodule

// File: rtl/branch_hazard_unit.sv
// ID-stage branch hazard unit: operand forwarding selects, multi-cycle stall
// sequencing for BEQ/BNE, taken-branch IF/ID flush and stall statistics.
module branch_hazard_unit
  import branch_hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int OPCODE_W   = 6,
  parameter int FWD_EN     = 1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [OPCODE_W-1:0]   id_opcode,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  ex_regwrite,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  mem_regwrite,
  input  logic                  mem_memread,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  wb_regwrite,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  cmp_eq,
  output logic [1:0]            fwd_sel_a,
  output logic [1:0]            fwd_sel_b,
  output logic                  stall,
  output logic                  flush_ifid,
  output logic [CNT_W-1:0]      stall_cycles
);

  state_e     state, state_nx;
  logic [1:0] cnt, cnt_nx;

  logic       is_beq, is_bne, branch, taken;
  logic [1:0] sel_a, sel_b, need_a, need_b, n_req;

  assign is_beq = (id_opcode == OPCODE_W'(OP_BEQ));
  assign is_bne = (id_opcode == OPCODE_W'(OP_BNE));
  assign branch = id_valid && (is_beq || is_bne);
  assign taken  = (is_beq && cmp_eq) || (is_bne && !cmp_eq);

  src_hazard_check #(.REG_ADDR_W(REG_ADDR_W), .FWD_EN(FWD_EN)) u_chk_a (
    .src(id_rs),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_rd(mem_rd),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .fwd_sel(sel_a), .need(need_a)
  );

  src_hazard_check #(.REG_ADDR_W(REG_ADDR_W), .FWD_EN(FWD_EN)) u_chk_b (
    .src(id_rt),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_rd(mem_rd),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .fwd_sel(sel_b), .need(need_b)
  );

  assign n_req = branch ? max2(need_a, need_b) : 2'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // The first stall cycle is issued from RUN, so HOLD covers the remaining N-1.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ST_RUN: begin
        if (n_req > 2'd1) begin
          state_nx = ST_HOLD;
          cnt_nx   = n_req - 2'd1;
        end
      end
      ST_HOLD: begin
        cnt_nx = cnt - 2'd1;
        if (cnt == 2'd1) state_nx = ST_RUN;
      end
      default: begin
        state_nx = ST_RUN;
        cnt_nx   = '0;
      end
    endcase
  end

  always_comb begin
    stall      = (state == ST_HOLD) || (n_req != 2'd0);
    flush_ifid = branch && !stall && (state == ST_RUN) && taken;
    fwd_sel_a  = branch ? sel_a : FWD_RF;
    fwd_sel_b  = branch ? sel_b : FWD_RF;
  end

  always_ff @(posedge clk) begin
    if (rst)                                  stall_cycles <= '0;
    else if (stall && (stall_cycles != '1))   stall_cycles <= stall_cycles + 1'b1;
  end

endmodule

// File: tb/tb_branch_hazard_unit.sv
// Directed bench for branch_hazard_unit: a forwarding instance (16-bit stats)
// and a no-forwarding instance with a 2-bit stats counter to reach saturation.
module tb_branch_hazard_unit;

  logic       clk = 1'b0;
  logic       rst0, rst1;
  logic       id_valid;
  logic [5:0] id_opcode;
  logic [4:0] id_rs, id_rt;
  logic       ex_regwrite, ex_memread;
  logic [4:0] ex_rd;
  logic       mem_regwrite, mem_memread;
  logic [4:0] mem_rd;
  logic       wb_regwrite;
  logic [4:0] wb_rd;
  logic       cmp_eq;

  logic [1:0]  fa0, fb0, fa1, fb1;
  logic        st0, fl0, st1, fl1;
  logic [15:0] sc0;
  logic [1:0]  sc1;

  int npass  = 0;
  int ntotal = 0;

  typedef struct {
    string       tag;
    bit          which;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        st;
    logic        fl;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  branch_hazard_unit #(.REG_ADDR_W(5), .OPCODE_W(6), .FWD_EN(1), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst0), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_rd(mem_rd),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .cmp_eq(cmp_eq),
    .fwd_sel_a(fa0), .fwd_sel_b(fb0), .stall(st0), .flush_ifid(fl0),
    .stall_cycles(sc0)
  );

  branch_hazard_unit #(.REG_ADDR_W(5), .OPCODE_W(6), .FWD_EN(0), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst1), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_rd(mem_rd),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .cmp_eq(cmp_eq),
    .fwd_sel_a(fa1), .fwd_sel_b(fb1), .stall(st1), .flush_ifid(fl1),
    .stall_cycles(sc1)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic idle();
    id_valid = 0; id_opcode = 6'b000000; id_rs = 0; id_rt = 0;
    ex_regwrite = 0; ex_memread = 0; ex_rd = 0;
    mem_regwrite = 0; mem_memread = 0; mem_rd = 0;
    wb_regwrite = 0; wb_rd = 0; cmp_eq = 0;
  endtask

  task automatic br(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic eq);
    id_valid = 1; id_opcode = op; id_rs = rs; id_rt = rt; cmp_eq = eq;
  endtask

  // Push the expectation for the inputs just driven, then compare at the
  // falling edge and advance to just after the next rising edge.
  task automatic step(input string tag, input bit which, input logic [1:0] fa,
                      input logic [1:0] fb, input logic st, input logic fl,
                      input logic [15:0] cnt);
    exp_t e;
    sb.push_back('{tag: tag, which: which, fa: fa, fb: fb, st: st, fl: fl, cnt: cnt});
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.which == 1'b0) begin
        chk({e.tag, ".fwd_a"}, {14'd0, fa0}, {14'd0, e.fa});
        chk({e.tag, ".fwd_b"}, {14'd0, fb0}, {14'd0, e.fb});
        chk({e.tag, ".stall"}, {15'd0, st0}, {15'd0, e.st});
        chk({e.tag, ".flush"}, {15'd0, fl0}, {15'd0, e.fl});
        chk({e.tag, ".cycles"}, sc0, e.cnt);
      end else begin
        chk({e.tag, ".fwd_a"}, {14'd0, fa1}, {14'd0, e.fa});
        chk({e.tag, ".fwd_b"}, {14'd0, fb1}, {14'd0, e.fb});
        chk({e.tag, ".stall"}, {15'd0, st1}, {15'd0, e.st});
        chk({e.tag, ".flush"}, {15'd0, fl1}, {15'd0, e.fl});
        chk({e.tag, ".cycles"}, {14'd0, sc1}, e.cnt);
      end
    end
    @(posedge clk); #1;
  endtask

  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101;

  initial begin
    idle();
    rst0 = 1; rst1 = 1;
    @(posedge clk); #1;

    step("reset", 0, 2'b00, 2'b00, 0, 0, 16'd0);
    rst0 = 0;

    // Non-branch opcode with a load hazard on rs: no effect.
    id_valid = 1; id_opcode = 6'b000000; id_rs = 8; id_rt = 3; cmp_eq = 1;
    ex_regwrite = 1; ex_memread = 1; ex_rd = 8;
    step("nonbranch", 0, 2'b00, 2'b00, 0, 0, 16'd0);

    // BEQ rs=8 behind lw $8: two stall cycles, then forward from MEM/WB.
    idle(); br(BEQ, 8, 3, 1); ex_regwrite = 1; ex_memread = 1; ex_rd = 8;
    step("lw_ex_s1", 0, 2'b00, 2'b00, 1, 0, 16'd0);
    idle(); br(BEQ, 8, 3, 1); mem_regwrite = 1; mem_memread = 1; mem_rd = 8;
    step("lw_ex_s2", 0, 2'b00, 2'b00, 1, 0, 16'd1);
    idle(); br(BEQ, 8, 3, 0); wb_regwrite = 1; wb_rd = 8;
    step("lw_ex_go", 0, 2'b10, 2'b00, 0, 0, 16'd2);

    // BNE rt=9, ALU result in MEM beats WB copy.
    idle(); br(BNE, 1, 9, 0); mem_regwrite = 1; mem_rd = 9; wb_regwrite = 1; wb_rd = 9;
    step("prio_mem", 0, 2'b00, 2'b01, 0, 1, 16'd2);

    // $0 never matches.
    idle(); br(BEQ, 0, 0, 0);
    ex_regwrite = 1; ex_memread = 1; ex_rd = 0;
    mem_regwrite = 1; mem_rd = 0; wb_regwrite = 1; wb_rd = 0;
    step("reg0", 0, 2'b00, 2'b00, 0, 0, 16'd2);

    idle(); br(BEQ, 2, 3, 1);
    step("beq_taken", 0, 2'b00, 2'b00, 0, 1, 16'd2);
    idle(); br(BNE, 2, 3, 1);
    step("bne_not_taken", 0, 2'b00, 2'b00, 0, 0, 16'd2);

    // ALU producer in EX: one stall, then EX/MEM forward.
    idle(); br(BEQ, 2, 4, 1); ex_regwrite = 1; ex_rd = 4;
    step("alu_ex", 0, 2'b00, 2'b00, 1, 0, 16'd2);
    idle(); br(BEQ, 2, 4, 1); mem_regwrite = 1; mem_rd = 4;
    step("alu_mem_fwd", 0, 2'b00, 2'b01, 0, 1, 16'd3);

    // Load in MEM: one stall.
    idle(); br(BNE, 6, 0, 0); mem_regwrite = 1; mem_memread = 1; mem_rd = 6;
    step("lw_mem", 0, 2'b00, 2'b00, 1, 0, 16'd3);

    // Max over sources (1 vs 2), and id_valid dropping mid-HOLD.
    idle(); br(BEQ, 10, 11, 0);
    mem_regwrite = 1; mem_memread = 1; mem_rd = 10;
    ex_regwrite = 1; ex_memread = 1; ex_rd = 11;
    step("max_s1", 0, 2'b00, 2'b00, 1, 0, 16'd4);
    idle();
    step("hold_novalid", 0, 2'b00, 2'b00, 1, 0, 16'd5);
    step("after_hold", 0, 2'b00, 2'b00, 0, 0, 16'd6);

    // Reset in the second stall cycle ends the hold and clears statistics.
    idle(); br(BEQ, 8, 3, 0); ex_regwrite = 1; ex_memread = 1; ex_rd = 8;
    step("rst_s1", 0, 2'b00, 2'b00, 1, 0, 16'd6);
    rst0 = 1;
    step("rst_s2", 0, 2'b00, 2'b00, 1, 0, 16'd7);
    rst0 = 0; idle();
    step("rst_after", 0, 2'b00, 2'b00, 0, 0, 16'd0);

    // No-forwarding instance, 2-bit statistics counter.
    idle();
    step("nf_reset", 1, 2'b00, 2'b00, 0, 0, 16'd0);
    rst1 = 0;
    br(BEQ, 5, 1, 1); ex_regwrite = 1; ex_rd = 5;
    step("nf_s1", 1, 2'b00, 2'b00, 1, 0, 16'd0);
    idle(); br(BEQ, 5, 1, 1); mem_regwrite = 1; mem_rd = 5;
    step("nf_s2", 1, 2'b00, 2'b00, 1, 0, 16'd1);
    idle(); br(BEQ, 5, 1, 1); wb_regwrite = 1; wb_rd = 5;
    step("nf_s3", 1, 2'b00, 2'b00, 1, 0, 16'd2);
    idle(); br(BEQ, 5, 1, 1);
    step("nf_go", 1, 2'b00, 2'b00, 0, 1, 16'd3);
    idle(); br(BEQ, 6, 1, 0); wb_regwrite = 1; wb_rd = 6;
    step("nf_wb", 1, 2'b00, 2'b00, 1, 0, 16'd3);
    idle();
    step("nf_sat", 1, 2'b00, 2'b00, 0, 0, 16'd3);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
